// File: rtl/matrix_fb_slave_pkg.sv
// Shared globals for the matrix framebuffer slave: register map, window geometry,
// Wishbone cycle-type encodings and the bus FSM state type.
package matrix_fb_slave_pkg;

   localparam logic [11:0] MATRIX_START       = 12'h000;
   localparam logic [11:0] MATRIX_ADDR_L      = 12'h800;
   localparam logic [11:0] MATRIX_ADDR_H      = 12'h801;
   localparam logic [11:0] MATRIX_STATUS      = 12'h802;
   localparam logic [31:0] MATRIX_WINDOW      = 32'h0000_1000;
   localparam logic [11:0] MATRIX_PAGE_STRIDE = 12'h400;

   localparam logic [2:0]  CTI_CLASSIC = 3'b000;
   localparam logic [2:0]  CTI_INCR    = 3'b010;
   localparam logic [2:0]  CTI_END     = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACK,
      ST_BURST
   } bus_state_e;

endpackage

// File: rtl/fb_dual_port_ram.sv
// One byte lane of pixel storage: 1024 x 8, combinational bus read/write port
// plus a registered scanout read port.
module fb_dual_port_ram (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       bus_we_i,
   input  logic [9:0] bus_addr_i,
   input  logic [7:0] bus_wdata_i,
   output logic [7:0] bus_rdata_o,
   input  logic [9:0] scan_addr_i,
   output logic [7:0] scan_rdata_o
);

   logic [7:0] mem_q [1024];
   logic [7:0] scan_q;

   always_ff @(posedge clk_i) begin
      if (bus_we_i) mem_q[bus_addr_i] <= bus_wdata_i;
   end

   assign bus_rdata_o = mem_q[bus_addr_i];

   // Same-edge write/scan collision returns the old byte (non-blocking read).
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) scan_q <= '0;
      else       scan_q <= mem_q[scan_addr_i];
   end

   assign scan_rdata_o = scan_q;

endmodule

// File: rtl/matrix_fb_slave.sv
// Wishbone slave for a double-buffered 16x32 RGB565 LED matrix framebuffer with
// frame-synchronous page flipping.
module matrix_fb_slave #(
   parameter int unsigned ADDRESS_WIDTH = 16,
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned DATA_BYTES    = 1,
   parameter int unsigned BASE_ADDRESS  = 0
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [ADDRESS_WIDTH-1:0] adr_i,
   input  logic [DATA_WIDTH-1:0]    dat_i,
   output logic [DATA_WIDTH-1:0]    dat_o,
   input  logic                     we_i,
   input  logic [DATA_BYTES-1:0]    sel_i,
   input  logic                     stb_i,
   input  logic                     cyc_i,
   output logic                     ack_o,
   input  logic [2:0]               cti_i,
   input  logic [8:0]               scan_addr,
   output logic [15:0]              scan_pixel,
   input  logic                     frame_sync,
   output logic                     flip_done
);
   import matrix_fb_slave_pkg::*;

   logic [ADDRESS_WIDTH-1:0] off;
   logic [11:0]              off12;
   logic                     hit, wr_en, pix_we, wr_l, wr_h, do_flip;
   bus_state_e               state_q, state_d;
   logic [15:0]              pending_addr_q;
   logic                     pending_q, active_page_q, flip_done_q;
   logic [7:0]               ram_rd_lo, ram_rd_hi, scan_lo, scan_hi, rd_byte;

   assign off   = adr_i - ADDRESS_WIDTH'(BASE_ADDRESS);
   assign off12 = off[11:0];
   assign hit   = cyc_i & stb_i & (32'(off) < MATRIX_WINDOW);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (hit) state_d = (cti_i == CTI_INCR) ? ST_BURST : ST_ACK;
         ST_ACK:   state_d = ST_IDLE;
         ST_BURST: if (!hit || cti_i == CTI_END) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Ack is gated by the live hit so the async reset of state_q drops it at once.
   assign ack_o   = hit & (state_q != ST_IDLE);
   assign wr_en   = ack_o & we_i & sel_i[0];
   assign pix_we  = wr_en & ~off12[11];
   assign wr_l    = wr_en & (off12 == MATRIX_ADDR_L);
   assign wr_h    = wr_en & (off12 == MATRIX_ADDR_H);
   assign do_flip = frame_sync & pending_q & ~wr_h;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pending_addr_q <= '0;
         pending_q      <= 1'b0;
         active_page_q  <= 1'b0;
         flip_done_q    <= 1'b0;
      end else begin
         flip_done_q <= do_flip;
         if (wr_l) pending_addr_q[7:0] <= dat_i[7:0];
         if (wr_h) begin
            pending_addr_q[15:8] <= dat_i[7:0];
            pending_q            <= 1'b1;
         end else if (do_flip) begin
            pending_q <= 1'b0;
         end
         if (do_flip) active_page_q <= pending_addr_q[10];
      end
   end

   always_comb begin
      rd_byte = '0;
      if (!off12[11]) begin
         rd_byte = off12[0] ? ram_rd_hi : ram_rd_lo;
      end else begin
         unique case (off12)
            MATRIX_ADDR_L: rd_byte = pending_addr_q[7:0];
            MATRIX_ADDR_H: rd_byte = pending_addr_q[15:8];
            MATRIX_STATUS: rd_byte = {6'b0, active_page_q, pending_q};
            default:       rd_byte = '0;
         endcase
      end
   end

   assign dat_o      = (ack_o & ~we_i) ? DATA_WIDTH'(rd_byte) : '0;
   assign scan_pixel = {scan_hi, scan_lo};
   assign flip_done  = flip_done_q;

   fb_dual_port_ram u_ram_lo (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .bus_we_i     (pix_we & ~off12[0]),
      .bus_addr_i   (off12[10:1]),
      .bus_wdata_i  (dat_i[7:0]),
      .bus_rdata_o  (ram_rd_lo),
      .scan_addr_i  ({active_page_q, scan_addr}),
      .scan_rdata_o (scan_lo)
   );

   fb_dual_port_ram u_ram_hi (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .bus_we_i     (pix_we & off12[0]),
      .bus_addr_i   (off12[10:1]),
      .bus_wdata_i  (dat_i[7:0]),
      .bus_rdata_o  (ram_rd_hi),
      .scan_addr_i  ({active_page_q, scan_addr}),
      .scan_rdata_o (scan_hi)
   );

endmodule

// File: tb/tb_matrix_fb_slave.sv
// Directed self-checking bench for matrix_fb_slave: bus decode, burst timing,
// pixel scanout and frame-synchronous page flipping.
module tb_matrix_fb_slave;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] adr = '0;
   logic [7:0]  dat_i = '0;
   logic [7:0]  dat_o;
   logic        we = 1'b0;
   logic [0:0]  sel = 1'b0;
   logic        stb = 1'b0;
   logic        cyc = 1'b0;
   logic        ack;
   logic [2:0]  cti = 3'b000;
   logic [8:0]  scan_addr = '0;
   logic [15:0] scan_pixel;
   logic        frame_sync = 1'b0;
   logic        flip_done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   matrix_fb_slave #(
      .ADDRESS_WIDTH (16),
      .DATA_WIDTH    (8),
      .DATA_BYTES    (1),
      .BASE_ADDRESS  (0)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .adr_i      (adr),
      .dat_i      (dat_i),
      .dat_o      (dat_o),
      .we_i       (we),
      .sel_i      (sel),
      .stb_i      (stb),
      .cyc_i      (cyc),
      .ack_o      (ack),
      .cti_i      (cti),
      .scan_addr  (scan_addr),
      .scan_pixel (scan_pixel),
      .frame_sync (frame_sync),
      .flip_done  (flip_done)
   );

   // Classic single transfer; optionally pulses frame_sync in the ack cycle.
   task automatic bus_xfer(input logic [15:0] a, input logic wr, input logic [7:0] wd,
                           input logic fs_on_ack, output logic [7:0] rd, output logic ok);
      ok = 1'b0;
      rd = '0;
      @(posedge clk); #1;
      adr = a; we = wr; dat_i = wd; sel = 1'b1; cyc = 1'b1; stb = 1'b1; cti = 3'b000;
      for (int n = 0; n < 8 && !ok; n++) begin
         @(negedge clk);
         if (ack === 1'b1) begin
            ok = 1'b1;
            rd = dat_o;
            if (fs_on_ack) frame_sync = 1'b1;
         end
         @(posedge clk); #1;
         frame_sync = 1'b0;
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   task automatic test_reset();
      logic [7:0] rd;
      logic ok;
      int acks;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", ack); end
      checks++; if (dat_o !== 8'h00) begin errors++; $display("FAIL reset_dat got %h exp 00", dat_o); end
      checks++; if (flip_done !== 1'b0) begin errors++; $display("FAIL reset_flip got %b exp 0", flip_done); end
      checks++; if (scan_pixel !== 16'h0000) begin errors++; $display("FAIL reset_scan got %h exp 0000", scan_pixel); end
      @(posedge clk); #1;
      rst = 1'b0;
      bus_xfer(16'h0802, 1'b0, 8'h00, 1'b0, rd, ok);
      checks++; if (!ok || rd !== 8'h00) begin errors++; $display("FAIL status_after_reset got ok=%b %h exp ok=1 00", ok, rd); end
      acks = 0;
      @(posedge clk); #1;
      adr = 16'h1000; cyc = 1'b1; stb = 1'b1; we = 1'b0; cti = 3'b000;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (ack === 1'b1) acks++;
      end
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0;
      checks++; if (acks != 0) begin errors++; $display("FAIL out_of_window_ack got %0d exp 0", acks); end
   endtask

   task automatic test_classic_spacing();
      int acks;
      logic prev, consecutive;
      acks = 0; prev = 1'b0; consecutive = 1'b0;
      @(posedge clk); #1;
      adr = 16'h0802; cyc = 1'b1; stb = 1'b1; we = 1'b0; cti = 3'b000;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (ack === 1'b1) begin
            acks++;
            if (prev) consecutive = 1'b1;
         end
         prev = (ack === 1'b1);
      end
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0;
      checks++; if (acks != 3 || consecutive) begin errors++; $display("FAIL classic_spacing got acks=%0d consec=%b exp 3 0", acks, consecutive); end
   endtask

   task automatic test_pixel_write();
      logic [7:0] rd;
      logic ok;
      bus_xfer(16'h0002, 1'b1, 8'hE0, 1'b0, rd, ok);
      bus_xfer(16'h0003, 1'b1, 8'h07, 1'b0, rd, ok);
      scan_addr = 9'h001;
      @(posedge clk); #1;
      checks++; if (scan_pixel !== 16'h07E0) begin errors++; $display("FAIL scan_pixel_p0 got %h exp 07E0", scan_pixel); end
      bus_xfer(16'h0003, 1'b0, 8'h00, 1'b0, rd, ok);
      checks++; if (!ok || rd !== 8'h07) begin errors++; $display("FAIL pixel_readback got %h exp 07", rd); end
   endtask

   task automatic test_burst();
      logic [7:0] bd [3];
      logic [7:0] rd;
      logic ok;
      int acks;
      bd[0] = 8'h11; bd[1] = 8'h22; bd[2] = 8'h33;
      acks = 0;
      @(posedge clk); #1;
      adr = 16'h0400; dat_i = bd[0]; we = 1'b1; sel = 1'b1; cyc = 1'b1; stb = 1'b1; cti = 3'b010;
      @(negedge clk);
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL burst_latency got %b exp 0", ack); end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         adr = 16'h0400 + 16'(i); dat_i = bd[i];
         cti = (i == 2) ? 3'b111 : 3'b010;
         @(negedge clk);
         if (ack === 1'b1) acks++;
      end
      checks++; if (acks != 3) begin errors++; $display("FAIL burst_acks got %0d exp 3", acks); end
      @(posedge clk); #1;
      we = 1'b0; cti = 3'b000; adr = 16'h0802;
      @(negedge clk);
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL burst_to_idle got %b exp 0", ack); end
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus_xfer(16'h0400 + 16'(i), 1'b0, 8'h00, 1'b0, rd, ok);
         checks++; if (!ok || rd !== bd[i]) begin errors++; $display("FAIL burst_readback[%0d] got %h exp %h", i, rd, bd[i]); end
      end
   endtask

   task automatic test_unmapped();
      logic [7:0] rd;
      logic ok;
      bus_xfer(16'h0900, 1'b1, 8'hFF, 1'b0, rd, ok);
      checks++; if (!ok) begin errors++; $display("FAIL unmapped_write_ack got %b exp 1", ok); end
      bus_xfer(16'h0900, 1'b0, 8'h00, 1'b0, rd, ok);
      checks++; if (!ok || rd !== 8'h00) begin errors++; $display("FAIL unmapped_read got %h exp 00", rd); end
      bus_xfer(16'h0800, 1'b1, 8'h5C, 1'b0, rd, ok);
      bus_xfer(16'h0800, 1'b0, 8'h00, 1'b0, rd, ok);
      checks++; if (rd !== 8'h5C) begin errors++; $display("FAIL fb_addr_l_rw got %h exp 5C", rd); end
      bus_xfer(16'h0802, 1'b0, 8'h00, 1'b0, rd, ok);
      checks++; if (rd !== 8'h00) begin errors++; $display("FAIL l_write_no_pending got %h exp 00", rd); end
   endtask

   task automatic test_flip();
      logic [7:0] rd;
      logic ok;
      bus_xfer(16'h0800, 1'b1, 8'h00, 1'b0, rd, ok);
      bus_xfer(16'h0801, 1'b1, 8'h04, 1'b0, rd, ok);
      bus_xfer(16'h0802, 1'b0, 8'h00, 1'b0, rd, ok);
      checks++; if (rd !== 8'h01) begin errors++; $display("FAIL status_pending got %h exp 01", rd); end
      @(posedge clk); #1;
      frame_sync = 1'b1;
      @(posedge clk); #1;
      frame_sync = 1'b0;
      checks++; if (flip_done !== 1'b1) begin errors++; $display("FAIL flip_done_pulse got %b exp 1", flip_done); end
      scan_addr = 9'h000;
      @(posedge clk); #1;
      checks++; if (flip_done !== 1'b0) begin errors++; $display("FAIL flip_done_single got %b exp 0", flip_done); end
      checks++; if (scan_pixel !== 16'h2211) begin errors++; $display("FAIL scan_pixel_p1 got %h exp 2211", scan_pixel); end
      bus_xfer(16'h0802, 1'b0, 8'h00, 1'b0, rd, ok);
      checks++; if (rd !== 8'h02) begin errors++; $display("FAIL status_flipped got %h exp 02", rd); end
   endtask

   task automatic test_flip_deferred();
      logic [7:0] rd;
      logic ok;
      bus_xfer(16'h0801, 1'b1, 8'h00, 1'b1, rd, ok);
      checks++; if (!ok || flip_done !== 1'b0) begin errors++; $display("FAIL deferred_no_flip got ok=%b flip=%b exp 1 0", ok, flip_done); end
      bus_xfer(16'h0802, 1'b0, 8'h00, 1'b0, rd, ok);
      checks++; if (rd !== 8'h03) begin errors++; $display("FAIL deferred_status got %h exp 03", rd); end
      @(posedge clk); #1;
      frame_sync = 1'b1;
      @(posedge clk); #1;
      frame_sync = 1'b0;
      checks++; if (flip_done !== 1'b1) begin errors++; $display("FAIL deferred_flip got %b exp 1", flip_done); end
      scan_addr = 9'h001;
      @(posedge clk); #1;
      checks++; if (scan_pixel !== 16'h07E0) begin errors++; $display("FAIL deferred_scan_p0 got %h exp 07E0", scan_pixel); end
      bus_xfer(16'h0802, 1'b0, 8'h00, 1'b0, rd, ok);
      checks++; if (rd !== 8'h00) begin errors++; $display("FAIL deferred_status_after got %h exp 00", rd); end
   endtask

   task automatic test_reset_burst();
      logic [7:0] rd;
      logic ok;
      bus_xfer(16'h0411, 1'b1, 8'h5A, 1'b0, rd, ok);
      @(posedge clk); #1;
      adr = 16'h0410; dat_i = 8'hA1; we = 1'b1; sel = 1'b1; cyc = 1'b1; stb = 1'b1; cti = 3'b010;
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rst_burst_beat1 got %b exp 1", ack); end
      @(posedge clk); #1;
      adr = 16'h0411; dat_i = 8'hEE;
      #2;
      rst = 1'b1;
      #1;
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rst_async_ack got %b exp 0", ack); end
      @(posedge clk); #1;
      rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
      bus_xfer(16'h0410, 1'b0, 8'h00, 1'b0, rd, ok);
      checks++; if (!ok || rd !== 8'hA1) begin errors++; $display("FAIL rst_beat1_kept got %h exp A1", rd); end
      bus_xfer(16'h0411, 1'b0, 8'h00, 1'b0, rd, ok);
      checks++; if (!ok || rd !== 8'h5A) begin errors++; $display("FAIL rst_beat2_discarded got %h exp 5A", rd); end
   endtask

   initial begin
      test_reset();
      test_classic_spacing();
      test_pixel_write();
      test_burst();
      test_unmapped();
      test_flip();
      test_flip_deferred();
      test_reset_burst();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/matrix_fb_slave.md
MATRIX_FB_SLAVE -- requirements
Module: matrix_fb_slave

Interface
REQ-001 SHALL have parameters: ADDRESS_WIDTH, default 16, Wishbone address width; DATA_WIDTH, default 8, bus data width; DATA_BYTES, default 1, select width; BASE_ADDRESS, default 0, window base (4 KiB aligned).
REQ-002 SHALL have ports, one per line:
  - clk_i  in  1  system clock (one clock; all logic on rising edge).
  - rst_i  in  1  reset, asynchronous, active-high.
  - adr_i  in  ADDRESS_WIDTH  byte address.
  - dat_i  in  DATA_WIDTH  write data.
  - dat_o  out  DATA_WIDTH  read data.
  - we_i  in  1  write enable.
  - sel_i  in  DATA_BYTES  byte select.
  - stb_i  in  1  strobe.
  - cyc_i  in  1  cycle.
  - ack_o  out  1  acknowledge.
  - cti_i  in  3  cycle type (000 classic, 010 incrementing burst, 111 end of burst).
  - scan_addr  in  9  scanout address {row[3:0], col[4:0]}.
  - scan_pixel  out  16  RGB565 pixel of the active page.
  - frame_sync  in  1  one-cycle pulse at scanout frame boundary.
  - flip_done  out  1  one-cycle pulse when the active page changes.

Function
REQ-003 SHALL decode off = adr_i - BASE_ADDRESS; hit = cyc_i & stb_i & off < 0x1000; a non-hit SHALL never be acked.
REQ-004 SHALL map off 0x000-0x7FF to pixel RAM as {page, row[3:0], col[4:0], byte}; byte 0 = pixel[7:0], byte 1 = pixel[15:8].
REQ-005 SHALL map off 0x800 FB_ADDR_L (RW), 0x801 FB_ADDR_H (RW), 0x802 STATUS (RO, bit0 = pending, bit1 = active_page, others 0).
REQ-006 SHALL ack unmapped off 0x803-0xFFF, return 0 on read, ignore writes.
REQ-007 SHALL write only when hit & we_i & sel_i[0] in a cycle where ack_o is being asserted for that access.
REQ-008 SHALL implement bus FSM states IDLE, ACK, BURST.
REQ-009 IDLE: hit with cti_i = 010 -> BURST; any other hit -> ACK; ack_o asserted the following cycle (registered, 1-cycle latency).
REQ-010 ACK: ack_o = 1 for exactly one cycle, then IDLE; classic acks SHALL never occur on consecutive cycles.
REQ-011 BURST: ack_o held high each cycle while hit; cti_i = 111 or loss of hit -> IDLE after that beat; each beat uses current adr_i.
REQ-012 dat_o SHALL be valid in the cycle ack_o is high for a read and 0 otherwise.
REQ-013 Write to FB_ADDR_L SHALL update pending_addr[7:0] only; write to FB_ADDR_H SHALL update pending_addr[15:8] and set pending.
REQ-014 On frame_sync with pending set and no same-cycle FB_ADDR_H write: active_page <= pending_addr[10], pending cleared, flip_done pulses next cycle.
REQ-015 FB_ADDR_H write coinciding with frame_sync SHALL defer the flip to the next frame_sync; pending stays set.
REQ-016 scan_pixel SHALL equal RAM[{active_page, scan_addr}] registered, one cycle latency; page change affects reads issued the cycle after the flip.
REQ-017 Bus writes and scanout reads SHALL proceed simultaneously without stall; same-address collision returns old data on scan_pixel.

Reset
REQ-018 On rst_i: FSM IDLE, ack_o 0, dat_o 0, flip_done 0, scan_pixel 0, pending 0, pending_addr 0, active_page 0; pixel RAM contents not reset.
REQ-019 Reset asserted mid-burst SHALL drop ack_o immediately (asynchronously) and discard the in-flight write.

Structure
REQ-020 Register offsets (0x800-0x802), window size 0x1000, page stride 0x400 and cti encodings SHALL live in the shared globals header alongside MATRIX_START/MATRIX_ADDR_L.
REQ-021 Pixel storage SHALL be one sub-module, fb_dual_port_ram (1024 x 8 per byte lane, two instances, one write/read bus port, one read scan port).

Verification
REQ-022 Classic write 0xE0 to off 0x002 and 0x07 to 0x003 on page 0, scan_addr 0x001 -> scan_pixel 0x07E0 one cycle later.
REQ-023 Classic read of off 0x802 after reset -> one ack, dat_o 0x00; adr_i 0x1000 -> no ack for 16 cycles.
REQ-024 Burst cti 010,010,111 writing 0x11,0x22,0x33 at 0x400-0x402 -> three consecutive acks, then IDLE; readback matches.
REQ-025 Write FB_ADDR_L 0x00, FB_ADDR_H 0x04, then frame_sync -> STATUS 0x02, flip_done single pulse, scan_pixel sourced from page 1.
REQ-026 FB_ADDR_H write in same cycle as frame_sync -> no flip, STATUS bit0 = 1; next frame_sync flips.
REQ-027 rst_i asserted during burst beat 2 -> ack_o low same cycle, byte at beat 2 address unchanged.
